// File: rtl/dcache_req_arb_if.sv
// Bundle of request/response signals between the requesters, the arbiter and the data cache.
// The slave modport is the arbiter's view; the master modport drives it.
interface dcache_req_arb_if #(
    parameter int NUM_REQS  = 2,
    parameter int NUM_LANES = 4,
    parameter int ADDR_W    = 30,
    parameter int DATA_W    = 32,
    parameter int TAG_IN_W  = 16,
    parameter int REQ_SEL_W = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1,
    parameter int TAG_OUT_W = TAG_IN_W + REQ_SEL_W
);
    logic [NUM_REQS*NUM_LANES-1:0]            req_in_valid;
    logic [NUM_REQS*NUM_LANES-1:0]            req_in_rw;
    logic [NUM_REQS*NUM_LANES*ADDR_W-1:0]     req_in_addr;
    logic [NUM_REQS*NUM_LANES*(DATA_W/8)-1:0] req_in_byteen;
    logic [NUM_REQS*NUM_LANES*DATA_W-1:0]     req_in_data;
    logic [NUM_REQS*NUM_LANES*TAG_IN_W-1:0]   req_in_tag;
    logic [NUM_REQS*NUM_LANES-1:0]            req_in_ready;

    logic [NUM_LANES-1:0]                     req_out_valid;
    logic [NUM_LANES-1:0]                     req_out_rw;
    logic [NUM_LANES*ADDR_W-1:0]              req_out_addr;
    logic [NUM_LANES*(DATA_W/8)-1:0]          req_out_byteen;
    logic [NUM_LANES*DATA_W-1:0]              req_out_data;
    logic [NUM_LANES*TAG_OUT_W-1:0]           req_out_tag;
    logic [NUM_LANES-1:0]                     req_out_ready;

    logic                                     rsp_in_valid;
    logic [NUM_LANES-1:0]                     rsp_in_tmask;
    logic [NUM_LANES*DATA_W-1:0]              rsp_in_data;
    logic [TAG_OUT_W-1:0]                     rsp_in_tag;
    logic                                     rsp_in_ready;

    logic [NUM_REQS-1:0]                      rsp_out_valid;
    logic [NUM_LANES-1:0]                     rsp_out_tmask;
    logic [NUM_LANES*DATA_W-1:0]              rsp_out_data;
    logic [TAG_IN_W-1:0]                      rsp_out_tag;
    logic [NUM_REQS-1:0]                      rsp_out_ready;

    modport slave (
        input  req_in_valid, req_in_rw, req_in_addr, req_in_byteen, req_in_data, req_in_tag,
        output req_in_ready,
        output req_out_valid, req_out_rw, req_out_addr, req_out_byteen, req_out_data, req_out_tag,
        input  req_out_ready,
        input  rsp_in_valid, rsp_in_tmask, rsp_in_data, rsp_in_tag,
        output rsp_in_ready,
        output rsp_out_valid, rsp_out_tmask, rsp_out_data, rsp_out_tag,
        input  rsp_out_ready
    );

    modport master (
        output req_in_valid, req_in_rw, req_in_addr, req_in_byteen, req_in_data, req_in_tag,
        input  req_in_ready,
        input  req_out_valid, req_out_rw, req_out_addr, req_out_byteen, req_out_data, req_out_tag,
        output req_out_ready,
        output rsp_in_valid, rsp_in_tmask, rsp_in_data, rsp_in_tag,
        input  rsp_in_ready,
        input  rsp_out_valid, rsp_out_tmask, rsp_out_data, rsp_out_tag,
        output rsp_out_ready
    );
endinterface

// File: rtl/dcache_req_arb.sv
// Round-robin arbiter sharing one multi-lane data-cache port among several requesters.
// A partially accepted request keeps the grant so lanes of different requesters never mix.
module dcache_req_arb #(
    parameter int NUM_REQS  = 2,
    parameter int NUM_LANES = 4,
    parameter int ADDR_W    = 30,
    parameter int DATA_W    = 32,
    parameter int TAG_IN_W  = 16,
    parameter int REQ_SEL_W = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1,
    parameter int TAG_OUT_W = TAG_IN_W + REQ_SEL_W
) (
    input logic           clk,
    input logic           reset,
    dcache_req_arb_if.slave bus
);
    localparam int BYTE_W = DATA_W / 8;

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t                 r_state, w_stateNext;
    logic [REQ_SEL_W-1:0]   r_grant, w_grantNext;
    logic [REQ_SEL_W-1:0]   r_rrPtr, w_rrPtrNext;
    logic [REQ_SEL_W-1:0]   w_sel, w_selIdle, w_selHigh, w_selLow;
    logic                   w_foundHigh, w_foundLow;
    logic [NUM_REQS-1:0]    w_reqAny;
    logic [NUM_LANES-1:0]   w_selValid, w_pending;
    logic [REQ_SEL_W-1:0]   w_rspIdx;
    logic                   w_rspIdxOk;

    function automatic logic [REQ_SEL_W-1:0] nextPtr(input logic [REQ_SEL_W-1:0] p);
        if (int'(p) >= NUM_REQS - 1) return '0;
        return p + REQ_SEL_W'(1);
    endfunction

    // Round-robin search: lowest active index at or above rr_ptr, else lowest overall (wrap).
    always_comb begin
        w_reqAny    = '0;
        w_selHigh   = '0;
        w_selLow    = '0;
        w_foundHigh = 1'b0;
        w_foundLow  = 1'b0;
        for (int r = NUM_REQS - 1; r >= 0; r--) begin
            w_reqAny[r] = |bus.req_in_valid[r*NUM_LANES +: NUM_LANES];
            if (w_reqAny[r]) begin
                w_selLow   = REQ_SEL_W'(r);
                w_foundLow = 1'b1;
                if (r >= int'(r_rrPtr)) begin
                    w_selHigh   = REQ_SEL_W'(r);
                    w_foundHigh = 1'b1;
                end
            end
        end
        w_selIdle = w_foundHigh ? w_selHigh : w_selLow;
    end

    assign w_sel     = (r_state == LOCKED) ? r_grant : w_selIdle;
    assign w_pending = w_selValid & ~bus.req_out_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_rrPtr <= '0;
        end else begin
            r_state <= w_stateNext;
            r_grant <= w_grantNext;
            r_rrPtr <= w_rrPtrNext;
        end
    end

    // A locked requester that withdraws its lanes releases the grant just like one that finishes.
    always_comb begin
        w_stateNext = r_state;
        w_grantNext = r_grant;
        w_rrPtrNext = r_rrPtr;
        case (r_state)
            IDLE: begin
                if (w_foundLow) begin
                    if (w_pending == '0) begin
                        w_rrPtrNext = nextPtr(w_sel);
                    end else begin
                        w_grantNext = w_sel;
                        w_stateNext = LOCKED;
                    end
                end
            end
            LOCKED: begin
                if (w_pending == '0) begin
                    w_stateNext = IDLE;
                    w_rrPtrNext = nextPtr(r_grant);
                end
            end
            default: w_stateNext = IDLE;
        endcase
    end

    always_comb begin
        w_selValid         = '0;
        bus.req_out_rw     = '0;
        bus.req_out_addr   = '0;
        bus.req_out_byteen = '0;
        bus.req_out_data   = '0;
        bus.req_out_tag    = '0;
        bus.req_in_ready   = '0;
        for (int r = 0; r < NUM_REQS; r++) begin
            if (w_sel == REQ_SEL_W'(r)) begin
                w_selValid         = bus.req_in_valid[r*NUM_LANES +: NUM_LANES];
                bus.req_out_rw     = bus.req_in_rw[r*NUM_LANES +: NUM_LANES];
                bus.req_out_addr   = bus.req_in_addr[r*NUM_LANES*ADDR_W +: NUM_LANES*ADDR_W];
                bus.req_out_byteen = bus.req_in_byteen[r*NUM_LANES*BYTE_W +: NUM_LANES*BYTE_W];
                bus.req_out_data   = bus.req_in_data[r*NUM_LANES*DATA_W +: NUM_LANES*DATA_W];
                for (int l = 0; l < NUM_LANES; l++) begin
                    bus.req_out_tag[l*TAG_OUT_W +: TAG_OUT_W] =
                        {w_sel, bus.req_in_tag[(r*NUM_LANES+l)*TAG_IN_W +: TAG_IN_W]};
                end
                if (reset) begin
                    bus.req_in_ready[r*NUM_LANES +: NUM_LANES] = bus.req_out_ready;
                end
            end
        end
        bus.req_out_valid = reset ? w_selValid : '0;
    end

    assign w_rspIdx   = bus.rsp_in_tag[TAG_OUT_W-1 -: REQ_SEL_W];
    assign w_rspIdxOk = int'(w_rspIdx) < NUM_REQS;

    // Out-of-range response indices are swallowed (ready=1) so the cache never stalls on them.
    always_comb begin
        bus.rsp_out_valid = '0;
        bus.rsp_in_ready  = 1'b1;
        for (int r = 0; r < NUM_REQS; r++) begin
            if (w_rspIdx == REQ_SEL_W'(r)) begin
                bus.rsp_out_valid[r] = reset & bus.rsp_in_valid;
                bus.rsp_in_ready     = bus.rsp_out_ready[r];
            end
        end
    end

    assign bus.rsp_out_tmask = bus.rsp_in_tmask;
    assign bus.rsp_out_data  = bus.rsp_in_data;
    assign bus.rsp_out_tag   = bus.rsp_in_tag[TAG_IN_W-1:0];

    assert property (@(posedge clk) disable iff (!reset) bus.rsp_in_valid |-> w_rspIdxOk)
        else $error("dcache_req_arb: response index out of range");

endmodule

// File: tb/tb_dcache_req_arb.sv
// Directed testbench for dcache_req_arb: stimulus pushes expected outputs into queues,
// independent monitors pop and compare whenever the DUT presents a request or response.
module tb_dcache_req_arb;
    localparam int NR  = 2;
    localparam int NL  = 4;
    localparam int AW  = 30;
    localparam int DW  = 32;
    localparam int TW  = 16;
    localparam int TOW = 17;

    typedef struct packed {
        logic [3:0] valid;
        logic [7:0] ready;
        logic       sel;
    } reqExp_t;

    typedef struct packed {
        logic [1:0]   outValid;
        logic         inReady;
        logic [3:0]   tmask;
        logic [15:0]  tag;
        logic [127:0] data;
    } rspExp_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    reqExp_t reqQ[$];
    rspExp_t rspQ[$];

    dcache_req_arb_if #(.NUM_REQS(NR), .NUM_LANES(NL), .ADDR_W(AW), .DATA_W(DW), .TAG_IN_W(TW)) bus();

    dcache_req_arb #(.NUM_REQS(NR), .NUM_LANES(NL), .ADDR_W(AW), .DATA_W(DW), .TAG_IN_W(TW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [NL*TOW-1:0] expTag(input logic sel);
        logic [NL*TOW-1:0] t;
        t = '0;
        for (int l = 0; l < NL; l++) t[l*TOW +: TOW] = {sel, 16'(16'h1000 * (int'(sel) + 1) + l)};
        return t;
    endfunction

    function automatic logic [NL*AW-1:0] expAddr(input logic sel);
        logic [NL*AW-1:0] a;
        a = '0;
        for (int l = 0; l < NL; l++) a[l*AW +: AW] = 30'(32'h100 * (int'(sel) + 1) + l);
        return a;
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic setResponse(input logic vld, input logic idx, input logic [15:0] tg,
                               input logic [3:0] tm, input logic [1:0] ordy,
                               input logic expRsp, input logic [1:0] eOut, input logic eRdy);
        bus.rsp_in_valid  = vld;
        bus.rsp_in_tag    = {idx, tg};
        bus.rsp_in_tmask  = tm;
        bus.rsp_in_data   = {4{tg, 16'h5A5A}};
        bus.rsp_out_ready = ordy;
        if (expRsp) rspQ.push_back('{eOut, eRdy, tm, tg, {4{tg, 16'h5A5A}}});
    endtask

    // One clock of request stimulus; reset cycles also check that every output is quiet.
    task automatic applyStimulus(input logic rstN, input logic [3:0] v0, input logic [3:0] v1,
                                 input logic [3:0] rdy, input logic expReq,
                                 input logic [3:0] eValid, input logic [7:0] eReady, input logic eSel);
        reset             = rstN;
        bus.req_in_valid  = {v1, v0};
        bus.req_out_ready = rdy;
        if (expReq) reqQ.push_back('{eValid, eReady, eSel});
        if (!rstN) begin
            @(negedge clk);
            checkOutput("reset_req_out_valid", 128'(bus.req_out_valid), 128'(0));
            checkOutput("reset_req_in_ready", 128'(bus.req_in_ready), 128'(0));
            checkOutput("reset_rsp_out_valid", 128'(bus.rsp_out_valid), 128'(0));
        end
        @(posedge clk);
        #1;
    endtask

    initial begin : reqMonitor
        reqExp_t e;
        forever begin
            @(negedge clk);
            if (|bus.req_out_valid) begin
                if (reqQ.size() == 0) begin
                    checkOutput("unexpected_req_out_valid", 128'(bus.req_out_valid), 128'(0));
                end else begin
                    e = reqQ.pop_front();
                    checkOutput("req_out_valid", 128'(bus.req_out_valid), 128'(e.valid));
                    checkOutput("req_in_ready", 128'(bus.req_in_ready), 128'(e.ready));
                    checkOutput("req_out_tag", 128'(bus.req_out_tag), 128'(expTag(e.sel)));
                    checkOutput("req_out_addr", 128'(bus.req_out_addr), 128'(expAddr(e.sel)));
                end
            end
        end
    end

    initial begin : rspMonitor
        rspExp_t e;
        forever begin
            @(negedge clk);
            if (|bus.rsp_out_valid) begin
                if (rspQ.size() == 0) begin
                    checkOutput("unexpected_rsp_out_valid", 128'(bus.rsp_out_valid), 128'(0));
                end else begin
                    e = rspQ.pop_front();
                    checkOutput("rsp_out_valid", 128'(bus.rsp_out_valid), 128'(e.outValid));
                    checkOutput("rsp_in_ready", 128'(bus.rsp_in_ready), 128'(e.inReady));
                    checkOutput("rsp_out_tmask", 128'(bus.rsp_out_tmask), 128'(e.tmask));
                    checkOutput("rsp_out_tag", 128'(bus.rsp_out_tag), 128'(e.tag));
                    checkOutput("rsp_out_data", bus.rsp_out_data, e.data);
                end
            end
        end
    end

    initial begin : stimulus
        reset              = 1'b0;
        bus.req_in_valid   = '0;
        bus.req_out_ready  = '0;
        bus.rsp_in_valid   = 1'b0;
        bus.rsp_in_tag     = '0;
        bus.rsp_in_tmask   = '0;
        bus.rsp_in_data    = '0;
        bus.rsp_out_ready  = '0;
        bus.req_in_byteen  = '1;
        for (int r = 0; r < NR; r++) begin
            for (int l = 0; l < NL; l++) begin
                bus.req_in_rw[r*NL+l]             = r[0];
                bus.req_in_addr[(r*NL+l)*AW +: AW] = 30'(32'h100 * (r + 1) + l);
                bus.req_in_data[(r*NL+l)*DW +: DW] = 32'hD000_0000 + 32'(r * 16 + l);
                bus.req_in_tag[(r*NL+l)*TW +: TW]  = 16'(16'h1000 * (r + 1) + l);
            end
        end
        @(posedge clk);
        #1;
        $display("[TB] reset with requests and a response pending");
        setResponse(1'b1, 1'b0, 16'h0F0F, 4'b1111, 2'b11, 1'b0, 2'b00, 1'b0);
        applyStimulus(1'b0, 4'b1111, 4'b1111, 4'b1111, 1'b0, 4'b0000, 8'h00, 1'b0);
        applyStimulus(1'b0, 4'b1111, 4'b1111, 4'b1111, 1'b0, 4'b0000, 8'h00, 1'b0);

        $display("[TB] full accept in one cycle with a simultaneous response");
        setResponse(1'b1, 1'b0, 16'h1111, 4'b1111, 2'b11, 1'b1, 2'b01, 1'b1);
        applyStimulus(1'b1, 4'b1111, 4'b0000, 4'b1111, 1'b1, 4'b1111, 8'h0F, 1'b0);
        setResponse(1'b0, 1'b0, 16'h0000, 4'b0000, 2'b00, 1'b0, 2'b00, 1'b0);

        $display("[TB] contention alternates grants starting at rr_ptr=1");
        applyStimulus(1'b1, 4'b0001, 4'b0001, 4'b1111, 1'b1, 4'b0001, 8'hF0, 1'b1);
        applyStimulus(1'b1, 4'b0001, 4'b0001, 4'b1111, 1'b1, 4'b0001, 8'h0F, 1'b0);
        applyStimulus(1'b1, 4'b0001, 4'b0001, 4'b1111, 1'b1, 4'b0001, 8'hF0, 1'b1);
        applyStimulus(1'b1, 4'b0001, 4'b0001, 4'b1111, 1'b1, 4'b0001, 8'h0F, 1'b0);

        $display("[TB] partial accept locks the grant");
        applyStimulus(1'b1, 4'b1111, 4'b0000, 4'b0011, 1'b1, 4'b1111, 8'h03, 1'b0);
        applyStimulus(1'b1, 4'b1100, 4'b1111, 4'b1100, 1'b1, 4'b1100, 8'h0C, 1'b0);
        applyStimulus(1'b1, 4'b0000, 4'b1111, 4'b1111, 1'b1, 4'b1111, 8'hF0, 1'b1);

        $display("[TB] withdrawal releases the lock and advances rr_ptr");
        applyStimulus(1'b1, 4'b0011, 4'b0000, 4'b0001, 1'b1, 4'b0011, 8'h01, 1'b0);
        applyStimulus(1'b1, 4'b0000, 4'b0011, 4'b0000, 1'b0, 4'b0000, 8'h00, 1'b0);
        applyStimulus(1'b1, 4'b0011, 4'b0011, 4'b1111, 1'b1, 4'b0011, 8'hF0, 1'b1);

        $display("[TB] response routing");
        setResponse(1'b1, 1'b1, 16'hBEEF, 4'b0101, 2'b10, 1'b1, 2'b10, 1'b1);
        applyStimulus(1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000, 8'h00, 1'b0);
        setResponse(1'b1, 1'b1, 16'hBEEF, 4'b0101, 2'b01, 1'b1, 2'b10, 1'b0);
        applyStimulus(1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000, 8'h00, 1'b0);
        setResponse(1'b1, 1'b0, 16'h1234, 4'b1010, 2'b01, 1'b1, 2'b01, 1'b1);
        applyStimulus(1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000, 8'h00, 1'b0);
        setResponse(1'b0, 1'b0, 16'h0000, 4'b0000, 2'b00, 1'b0, 2'b00, 1'b0);

        $display("[TB] reset while locked on requester 1");
        applyStimulus(1'b1, 4'b0000, 4'b1111, 4'b0001, 1'b1, 4'b1111, 8'h10, 1'b1);
        applyStimulus(1'b0, 4'b1111, 4'b1110, 4'b1111, 1'b0, 4'b0000, 8'h00, 1'b0);
        applyStimulus(1'b1, 4'b1111, 4'b1110, 4'b1111, 1'b1, 4'b1111, 8'h0F, 1'b0);
        applyStimulus(1'b1, 4'b0000, 4'b1110, 4'b1111, 1'b1, 4'b1110, 8'hF0, 1'b1);

        applyStimulus(1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000, 8'h00, 1'b0);
        applyStimulus(1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000, 8'h00, 1'b0);
        checkOutput("req_queue_drained", 128'(reqQ.size()), 128'(0));
        checkOutput("rsp_queue_drained", 128'(rspQ.size()), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dcache_req_arb.md
Name: dcache_req_arb

Overview:
- Shares one per-lane data-cache request/response port among NUM_REQS requesters: the LSU, plus the texture unit and other future memory clients.
- Selects one requester at a time by round-robin.
- Holds the grant until every lane of that requester's multi-lane request has been accepted, so lanes from different requesters never mix within one request.
- Appends the requester index to the tag and routes responses back by that index.

Parameters:
- NUM_REQS, 2, number of requesters; 1 gives a pass-through.
- NUM_LANES, 4, lanes per request (equals NUM_THREADS).
- ADDR_W, 30, word-address width.
- DATA_W, 32, data width per lane.
- TAG_IN_W, 16, requester tag width.
- REQ_SEL_W, derived, CLOG2(NUM_REQS), minimum 1.
- TAG_OUT_W, derived, TAG_IN_W+REQ_SEL_W.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous reset, active-low; asserted when 0.
- req_in_valid  in  NUM_REQS*NUM_LANES  per-requester, per-lane valid.
- req_in_rw  in  NUM_REQS*NUM_LANES  1 = write.
- req_in_addr  in  NUM_REQS*NUM_LANES*ADDR_W  word addresses.
- req_in_byteen  in  NUM_REQS*NUM_LANES*(DATA_W/8)  byte enables.
- req_in_data  in  NUM_REQS*NUM_LANES*DATA_W  write data.
- req_in_tag  in  NUM_REQS*NUM_LANES*TAG_IN_W  tags.
- req_in_ready  out  NUM_REQS*NUM_LANES  per-lane accept.
- req_out_valid/rw/addr/byteen/data  out  NUM_LANES*(field width)  to the data cache.
- req_out_tag  out  NUM_LANES*TAG_OUT_W  {requester index, req_in_tag}, index in the MSBs.
- req_out_ready  in  NUM_LANES  data-cache per-lane accept.
- rsp_in_valid  in  1  data-cache response valid.
- rsp_in_tmask  in  NUM_LANES  response lane mask.
- rsp_in_data  in  NUM_LANES*DATA_W  response data.
- rsp_in_tag  in  TAG_OUT_W  response tag.
- rsp_in_ready  out  1  response accept.
- rsp_out_valid  out  NUM_REQS  routed response valid.
- rsp_out_tmask/data/tag  out  NUM_LANES, NUM_LANES*DATA_W, TAG_IN_W  shared to all requesters.
- rsp_out_ready  in  NUM_REQS  per-requester response accept.

Behaviour:
- Reset (reset==0 at posedge):
  - state=IDLE, grant=0, rr_ptr=0.
  - All req_out_valid, req_in_ready and rsp_out_valid are 0 while reset is low.
  - Any in-flight lock is dropped.
  - Responses outstanding in the data cache are not tracked; the requesters must also be reset.
- Request presence: req_any[r] = |req_in_valid[r].
- IDLE:
  - Select the first r with req_any[r], searching from rr_ptr upward with wrap.
  - Selection is combinational: the selected requester's lanes drive req_out in the same cycle, so there are zero added cycles of latency.
  - If all active lanes fire this cycle: stay IDLE and set rr_ptr = sel+1 mod NUM_REQS.
  - Otherwise: grant<=sel and go to LOCKED.
- LOCKED:
  - Only requester `grant` drives the outputs; other requesters see ready=0.
  - Requesters drop lanes once each lane has fired.
  - Leave LOCKED in the cycle where (req_in_valid[grant] & ~req_out_ready)==0: go to IDLE with rr_ptr<=grant+1 mod NUM_REQS.
  - If req_in_valid[grant] becomes 0 without firing (withdrawn), also go to IDLE and advance rr_ptr.
- Lane mapping:
  - req_out_valid[l] = valid[sel][l].
  - req_in_ready[sel][l] = req_out_ready[l].
  - Other fields are muxed by sel; the tag gets sel prepended.
- Response routing:
  - idx = rsp_in_tag[TAG_OUT_W-1 -: REQ_SEL_W].
  - rsp_out_valid[idx] = rsp_in_valid; rsp_in_ready = rsp_out_ready[idx].
  - Responses are combinational and unregistered.
  - An idx >= NUM_REQS is a simulation assertion error; such a response is dropped with ready=1.
- Fairness: with all requesters continuously active, grants rotate 0,1,...,NUM_REQS-1. No requester waits more than NUM_REQS-1 complete requests.
- Request and response paths are independent; a simultaneous request grant and response delivery are both allowed.
- NUM_REQS==1: the FSM reduces to a pass-through and REQ_SEL_W=1 with index bit 0.

Test Plan:
- Single requester, NUM_REQS=2, req0 valid=4'b1111, req_out_ready=1111 -> fires in the same cycle, req_out_tag MSB=0, state stays IDLE, rr_ptr=1.
- Partial accept: req0 valid=1111, ready=0011 then 1100 -> cycle 1 lanes 0-1 fire and state=LOCKED. req1 valid=1111 sees ready=0000 in cycle 2 while lanes 2-3 fire. IDLE in cycle 3, then req1 is granted.
- Contention: both requesters valid=0001 every cycle, ready=1 -> grants alternate 0,1,0,1 and tag MSB alternates.
- Response routing: rsp_in_tag MSB=1, tmask=0101, rsp_out_ready=10 -> rsp_out_valid=10, rsp_in_ready=1. With rsp_out_ready=01 -> rsp_in_ready=0 and the response is held.
- Reset mid-lock: LOCKED on req1, then drive reset=0 for one cycle -> the next cycle all outputs are 0, state=IDLE, rr_ptr=0. After release, req0 and req1 both valid -> req0 is granted first.
- Withdrawal: LOCKED on req0 and req0 drops all valid without firing -> IDLE the next cycle, rr_ptr=1.
